// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-back cache; define CACHE_LRU_EN for true LRU, else round-robin
module set_assoc_cache #(
    parameter int CACHE_SIZE = 16384,
    parameter int BLOCK_SIZE = 128,
    parameter int WAYS       = 2,
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_SIZE  = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           crtl_en,
    input  logic                           crtl_wr_en,
    input  logic [DATA_SIZE/BYTE_SIZE-1:0] crtl_sel,
    input  logic [ADDR_SIZE-1:0]           crtl_addr,
    input  logic [DATA_SIZE-1:0]           crtl_wr_data,
    output logic [DATA_SIZE-1:0]           crtl_rd_data,
    output logic                           crtl_ack,
    output logic                           mem_en,
    output logic                           mem_wr_en,
    output logic [ADDR_SIZE-1:0]           mem_addr,
    output logic [BLOCK_SIZE-1:0]          mem_wr_data,
    input  logic [BLOCK_SIZE-1:0]          mem_rd_data,
    input  logic                           mem_ack
);

    localparam int SETS     = CACHE_SIZE / (BLOCK_SIZE * WAYS);
    localparam int OFFSET_W = $clog2(BLOCK_SIZE / BYTE_SIZE);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_SIZE - INDEX_W - OFFSET_W;
    localparam int BYTES    = DATA_SIZE / BYTE_SIZE;
    localparam int WORDS    = BLOCK_SIZE / DATA_SIZE;
    localparam int WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WORD_LSB = $clog2(BYTES);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t state_q, state_d;

    logic [ADDR_SIZE-1:0]  req_addr_q;
    logic                  req_wr_q;
    logic [BYTES-1:0]      req_sel_q;
    logic [DATA_SIZE-1:0]  req_wdata_q;

    logic [BLOCK_SIZE-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_index;
    logic [WSEL_W-1:0]     req_word;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_way;
    logic [WAY_W-1:0]      victim_q;
    logic [WAY_W-1:0]      repl_victim;
    logic                  victim_dirty;
    logic [BLOCK_SIZE-1:0] hit_line;
    logic [BLOCK_SIZE-1:0] merged_line;
    logic                  hit_done;
    logic                  fill;
    logic                  unused_addr_lsb;

    assign req_tag         = req_addr_q[ADDR_SIZE-1 -: TAG_W];
    assign req_index       = req_addr_q[OFFSET_W +: INDEX_W];
    assign req_word        = (WORDS > 1) ? req_addr_q[WORD_LSB +: WSEL_W] : '0;
    assign unused_addr_lsb = ^req_addr_q[WORD_LSB-1:0];
    assign hit_done        = (state_q == COMPARE) && hit;
    assign fill            = (state_q == ALLOCATE) && mem_ack;
    assign hit_line        = data_q[hit_way][req_index];
    assign victim_dirty    = valid_q[req_index][victim_way] && dirty_q[req_index][victim_way];

    // Tag compare across all ways of the addressed set; lowest matching way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_index][w] && tag_q[w][req_index] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way first, otherwise the replacement policy's choice
    always_comb begin
        logic found;
        found      = 1'b0;
        victim_way = repl_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[req_index][w]) begin
                found      = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
    end

    // Byte-enable merge of the write word into the hit line
    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < BYTES; b++) begin
            if (req_sel_q[b]) begin
                merged_line[int'(req_word)*DATA_SIZE + b*BYTE_SIZE +: BYTE_SIZE] =
                    req_wdata_q[b*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

`ifdef CACHE_LRU_EN
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic             touch;
    logic [WAY_W-1:0] touch_way;

    assign touch     = hit_done || fill;
    assign touch_way = fill ? victim_q : hit_way;

    // Oldest way (age WAYS-1) is the eviction candidate
    always_comb begin
        repl_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_index][w] == WAY_W'(WAYS - 1)) repl_victim = WAY_W'(w);
        end
    end

    // Accessed way becomes youngest; ways younger than its old age get one step older
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age_q[req_index][w] <= '0;
                else if (age_q[req_index][w] < age_q[req_index][touch_way])
                    age_q[req_index][w] <= age_q[req_index][w] + 1'b1;
            end
        end
    end
`else
    logic [WAY_W-1:0] rr_q [SETS];

    assign repl_victim = rr_q[req_index];

    // Round-robin pointer advances on every fill, including fills into invalid ways
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (fill) begin
            rr_q[req_index] <= (WAYS > 1) ? rr_q[req_index] + 1'b1 : '0;
        end
    end
`endif

    // Control state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (crtl_en && !crtl_ack) state_d = COMPARE;
            COMPARE:    if (hit)               state_d = IDLE;
                        else if (victim_dirty) state_d = WRITE_BACK;
                        else                   state_d = ALLOCATE;
            WRITE_BACK: if (mem_ack) state_d = ALLOCATE;
            ALLOCATE:   if (mem_ack) state_d = COMPARE;
            default:    state_d = IDLE;
        endcase
    end

    // Capture the request when a new one is accepted in IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            req_sel_q   <= '0;
            req_wdata_q <= '0;
        end else if (state_q == IDLE && crtl_en && !crtl_ack) begin
            req_addr_q  <= crtl_addr;
            req_wr_q    <= crtl_wr_en;
            req_sel_q   <= crtl_sel;
            req_wdata_q <= crtl_wr_data;
        end
    end

    // Completion pulse and registered read word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crtl_ack     <= 1'b0;
            crtl_rd_data <= '0;
        end else begin
            crtl_ack <= hit_done;
            if (hit_done && !req_wr_q)
                crtl_rd_data <= hit_line[int'(req_word)*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Memory-side outputs are registered on state transitions so they hold until mem_ack
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_en      <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            victim_q    <= '0;
        end else begin
            case (state_q)
                COMPARE: if (!hit) begin
                    mem_en   <= 1'b1;
                    victim_q <= victim_way;
                    if (victim_dirty) begin
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= {tag_q[victim_way][req_index], req_index, {OFFSET_W{1'b0}}};
                        mem_wr_data <= data_q[victim_way][req_index];
                    end else begin
                        mem_wr_en <= 1'b0;
                        mem_addr  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                    end
                end
                WRITE_BACK: if (mem_ack) begin
                    mem_wr_en <= 1'b0;
                    mem_addr  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                end
                ALLOCATE: if (mem_ack) begin
                    mem_en    <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Valid and dirty bits: fills install clean lines, write hits mark dirty
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (fill) begin
            valid_q[req_index][victim_q] <= 1'b1;
            dirty_q[req_index][victim_q] <= 1'b0;
        end else if (hit_done && req_wr_q) begin
            dirty_q[req_index][hit_way] <= 1'b1;
        end
    end

    // Line data and tag storage
    always_ff @(posedge clock) begin
        if (fill) begin
            data_q[victim_q][req_index] <= mem_rd_data;
            tag_q[victim_q][req_index]  <= req_tag;
        end else if (hit_done && req_wr_q) begin
            data_q[hit_way][req_index] <= merged_line;
        end
    end

endmodule
